// File: rtl/execute_muldiv.sv
// execute_muldiv: multi-cycle RISC-V M-extension unit (MUL*/DIV*/REM*, RV64 W forms), valid/ready in and out.
// Optional DIV_EARLY_OUT_EN: non-special div/rem with |a| < |b| completes one clock after accept.
module execute_muldiv #(
  parameter int XLEN    = 64,
  parameter int DST_W   = 7,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [DST_W-1:0] in_dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [DST_W-1:0] out_dst
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int   CW    = 8;
  localparam int   HALF  = XLEN / 2;
  localparam logic HAS_W = (XLEN == 64);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic [DST_W-1:0]  out_dst_q, out_dst_d;

  function automatic logic [XLEN-1:0] sx32(input logic [XLEN-1:0] v);
    return XLEN'(signed'(v[31:0]));
  endfunction

  function automatic logic [XLEN-1:0] zx32(input logic [XLEN-1:0] v);
    return XLEN'(v[31:0]);
  endfunction

  // Operand preparation shared by the multiplier and the divider setup clock
  logic                   ma_sgn, mb_sgn, d_sgn, sa, sb, bz, ovf;
  logic [XLEN-1:0]        m_a, m_b, a_x, b_x, mag_a, mag_b, min_v, mul_res;
  logic signed [XLEN:0]   ma, mb;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN:0]          r_sh;
  logic [XLEN-1:0]        r_sub, qv, rv;
  logic                   ge;
  logic [CW-1:0]          n_last;

  always_comb begin
    ma_sgn  = (op_q == 3'd1) || (op_q == 3'd2);
    mb_sgn  = (op_q == 3'd1);
    m_a     = word_q ? (ma_sgn ? sx32(a_q) : zx32(a_q)) : a_q;
    m_b     = word_q ? (mb_sgn ? sx32(b_q) : zx32(b_q)) : b_q;
    ma      = signed'({ma_sgn & m_a[XLEN-1], m_a});
    mb      = signed'({mb_sgn & m_b[XLEN-1], m_b});
    prod    = ma * mb;
    if (word_q)
      mul_res = (op_q == 3'd0) ? sx32(XLEN'(prod[31:0])) : sx32(XLEN'(prod[63:32]));
    else
      mul_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    d_sgn   = !op_q[0];
    a_x     = word_q ? (d_sgn ? sx32(a_q) : zx32(a_q)) : a_q;
    b_x     = word_q ? (d_sgn ? sx32(b_q) : zx32(b_q)) : b_q;
    sa      = d_sgn & a_x[XLEN-1];
    sb      = d_sgn & b_x[XLEN-1];
    mag_a   = sa ? -a_x : a_x;
    mag_b   = sb ? -b_x : b_x;
    min_v   = word_q ? sx32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    bz      = (b_x == '0);
    ovf     = d_sgn && (a_x == min_v) && (&b_x);

    r_sh    = {rem_q, quo_q[XLEN-1]};
    ge      = (r_sh >= {1'b0, b_q});
    r_sub   = r_sh[XLEN-1:0] - b_q;
    qv      = qneg_q ? -quo_q : quo_q;
    rv      = rneg_q ? -rem_q : rem_q;
    n_last  = word_q ? CW'(33) : CW'(XLEN + 1);
  end

  // cnt 0 = special-case check and magnitude load, 1..N = one quotient bit each, N+1 = sign fix
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    word_d     = word_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    a_d        = a_q;
    b_d        = b_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    out_dst_d  = out_dst_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d      = in_op;
          word_d    = in_word & HAS_W;
          a_d       = in_a;
          b_d       = in_b;
          out_dst_d = in_dst;
          cnt_d     = '0;
          state_d   = in_op[2] ? DIV : MUL;
        end
      end
      MUL: begin
        if (cnt_q == CW'(MUL_LAT - 1)) begin
          out_data_d = mul_res;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV: begin
        if (cnt_q == '0) begin
          if (bz || ovf) begin
            if (op_q[1]) out_data_d = word_q ? sx32(bz ? a_x : '0) : (bz ? a_x : '0);
            else         out_data_d = word_q ? sx32(bz ? '1 : a_x) : (bz ? '1 : a_x);
            state_d = DONE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (mag_a < mag_b) begin
            out_data_d = op_q[1] ? (word_q ? sx32(a_x) : a_x) : '0;
            state_d    = DONE;
          end
`endif
          else begin
            quo_d  = word_q ? (mag_a << HALF) : mag_a;
            rem_d  = '0;
            b_d    = mag_b;
            qneg_d = sa ^ sb;
            rneg_d = sa;
            cnt_d  = CW'(1);
          end
        end else if (cnt_q == n_last) begin
          out_data_d = word_q ? sx32(op_q[1] ? rv : qv) : (op_q[1] ? rv : qv);
          state_d    = DONE;
        end else begin
          rem_d = ge ? r_sub : r_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ge};
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      word_q     <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      out_data_q <= '0;
      out_dst_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      word_q     <= word_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      a_q        <= a_d;
      b_q        <= b_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
      out_dst_q  <= out_dst_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_dst   = out_dst_q;
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv (XLEN=64, MUL_LAT=3): results, latencies, hold, flush, async reset.
module tb_execute_muldiv;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_word, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [63:0] in_a, in_b, out_data;
  logic [6:0]  in_dst, out_dst;

  int n_chk = 0;
  int n_err = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 66;
`endif

  execute_muldiv #(.XLEN(64), .DST_W(7), .MUL_LAT(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_a(in_a), .in_b(in_b), .in_dst(in_dst),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dst(out_dst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op, wait for the result (bounded), check latency/data/tag, then drain it.
  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [6:0] dst,
                        input logic [63:0] exp_data, input int exp_lat);
    int   lat;
    logic busy_ok;
    chk({tag, "_rdy_before"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_word = w; in_a = a; in_b = b; in_dst = dst;
    tick();
    in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 200) begin
      if (out_valid) break;
      if (in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_dst"}, 64'(out_dst), 64'(dst));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] held_d;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 3'd0; in_word = 1'b0; in_a = '0; in_b = '0; in_dst = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_dst", 64'(out_dst), 64'd0);

    run_op("mul",    3'd0, 1'b0, 64'd7, -64'sd3, 7'd5, 64'hFFFF_FFFF_FFFF_FFEB, 3);
    run_op("mulhu",  3'd3, 1'b0, '1, '1, 7'd6, 64'hFFFF_FFFF_FFFF_FFFE, 3);
    run_op("mulh",   3'd1, 1'b0, '1, '1, 7'd7, 64'h0, 3);
    run_op("mulhsu", 3'd2, 1'b0, '1, '1, 7'd8, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    run_op("mulw",   3'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 7'd9, 64'hFFFF_FFFF_FFFF_FFFE, 3);
    run_op("div",    3'd4, 1'b0, -64'sd7, 64'd2, 7'd10, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run_op("rem",    3'd6, 1'b0, -64'sd7, 64'd2, 7'd11, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run_op("div_neg_b", 3'd4, 1'b0, 64'd100, -64'sd7, 7'd12, 64'hFFFF_FFFF_FFFF_FFF2, 66);
    run_op("remu",   3'd7, 1'b0, 64'd100, 64'd7, 7'd13, 64'd2, 66);
    run_op("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 7'd14, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("divu_b0", 3'd5, 1'b0, 64'd5, 64'd0, 7'd15, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_b0", 3'd7, 1'b0, 64'd5, 64'd0, 7'd16, 64'd5, 1);
    run_op("remw",   3'd6, 1'b1, 64'hAAAA_0000_FFFF_FFF9, 64'd3, 7'd17, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    run_op("divuw",  3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'd2, 7'd18, 64'h0000_0000_4000_0000, 34);
    run_op("divu_small", 3'd5, 1'b0, 64'd3, 64'd10, 7'd19, 64'd0, EARLY_LAT);

    // Hold a result with out_ready low, then flush it away while out_ready rises.
    in_valid = 1'b1; in_op = 3'd5; in_word = 1'b0; in_a = 64'd9; in_b = 64'd0; in_dst = 7'd33;
    tick();
    in_valid = 1'b0;
    tick();
    chk("hold_valid", 64'(out_valid), 64'd1);
    held_d = out_data;
    chk("hold_data0", held_d, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_stable", {out_valid, out_dst, out_data[55:0]}, {1'b1, 7'd33, held_d[55:0]});
    end
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);

    // Op offered during flush must not be taken.
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = 64'd2; in_b = 64'd3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_noacc_rdy", 64'(in_ready), 64'd1);
    repeat (5) tick();
    chk("flush_noacc_val", 64'(out_valid), 64'd0);

    // Flush in the middle of a long divide.
    in_valid = 1'b1; in_op = 3'd4; in_a = 64'd1000; in_b = 64'd3;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("middiv_busy", 64'(in_ready), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("middiv_flush", {62'd0, out_valid, in_ready}, 64'd1);
    repeat (70) tick();
    chk("middiv_noresult", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-divide takes effect before the next edge.
    in_valid = 1'b1; in_op = 3'd4; in_a = 64'd1000; in_b = 64'd3; in_dst = 7'd44;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_dst", 64'(out_dst), 64'd0);
    tick();
    reset = 1'b0;
    repeat (70) tick();
    chk("arst_noresult", 64'(out_valid), 64'd0);

    run_op("post_rst_mul", 3'd0, 1'b0, 64'd6, 64'd7, 7'd3, 64'd42, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
